ilb_line_buffer: RTL and testbench
==================================

Name: ilb_line_buffer

Overview:
- Input line buffer (ILB) for the streaming window path.
- Accepts one new pixel per transaction over the Transaction I handshake. Returns the six pixels in the same column of the six previous rows over the Transaction II handshake.
- Six cascaded line memories form a 7-row column: the new pixel plus six old rows.
- Sits directly downstream of the SoPU-side ILB interface for Transaction I, and upstream of it for Transaction II.

Parameters:
- IMG_WIDTH, 28, pixels per image row (line memory depth), minimum 2.
- COL_W, $clog2(IMG_WIDTH), column pointer width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- clear  in  1  synchronous frame restart: clears pointers and the fill count
- pixel_in  in  8  new pixel; valid while sop_to_ilb_rts_I=1
- sop_to_ilb_rts_I  in  1  upstream has a pixel ready
- sop_to_ilb_rtr_I  out  1  ILB ready to accept a pixel
- sop_to_ilb_rts_II  out  1  old-column bytes valid
- sop_to_ilb_rtr_II  in  1  downstream ready to take the bytes
- ilb_byte_0..ilb_byte_5  out  8 each  old pixels; ilb_byte_k is k+1 rows above the new pixel, same column
- lines_valid  out  3  count of fully written rows, saturating at 6
- col_ptr  out  COL_W  current column

Behaviour:
- Clock and reset:
  - One clock, clk. Reset rst is synchronous, active-high.
  - Reset drives all outputs to 0, state to IDLE, and col_ptr/lines_valid to 0.
  - Line RAM contents are not reset.
- States: IDLE, READ, WRITE, PRESENT.
- IDLE:
  - sop_to_ilb_rtr_I=1 (registered, so high from the first cycle after reset or clear releases); sop_to_ilb_rts_II=0.
  - On a rising edge with rts_I=1 and rtr_I=1: capture pixel_in, drop rtr_I, go to READ. This is the accept edge A.
  - Exactly one pixel is accepted per transaction. rts_I held high after acceptance is ignored because rtr_I is 0.
- READ: issue a synchronous read at col_ptr to all six line RAMs, then go to WRITE.
- WRITE:
  - Read-first writes at col_ptr: line0 <= captured pixel; line k <= old line k-1 for k=1..5.
  - Register ilb_byte_k = old line k, forced to 0 when k >= lines_valid.
  - col_ptr <= col_ptr+1, wrapping from IMG_WIDTH-1 to 0.
  - On wrap, lines_valid <= min(lines_valid+1, 6).
  - Set rts_II=1 and go to PRESENT. rts_II is first visible in the cycle after edge A+2.
- PRESENT:
  - Hold rts_II=1 and rtr_I=0.
  - On an edge with rtr_II=1: rts_II <= 0, go to IDLE.
- Output stability:
  - ilb_byte_* change only at the WRITE edge.
  - They stay stable through and after the Transaction II handshake, until the next accepted pixel's WRITE.
  - This allows the consumer to sample them several cycles after seeing rts_II.
- rtr_II already high when rts_II rises: completes on the first PRESENT edge.
- clear:
  - Any state: go to IDLE; rts_II=0; col_ptr=0; lines_valid=0; ilb_byte_* = 0; rtr_I=1 on the next cycle.
  - An in-flight pixel is discarded.
  - clear takes priority over handshakes. rst takes priority over clear.
- Reset or clear mid-WRITE: no partial column update is guaranteed. Subsequent masking by lines_valid=0 hides any stale data.
- Arithmetic: no pixel arithmetic; data is bit-exact 8-bit.
- Transaction throughput: one pixel per 4 cycles minimum (A, READ, WRITE, PRESENT with rtr_II already high).

Decomposition:
- Shared package (sopu_pkg):
  - ILB state encodings (2-bit).
  - NUM_ILB_LINES=6.
  - PIXEL_W=8.
- Sub-module: ilb_line_ram
  - Single-port, depth IMG_WIDTH, 8-bit, synchronous read, read-first on same-address write.
  - Instantiated six times through a generate loop.
  - Keeps BRAM inference clean.

Test Plan (IMG_WIDTH=4; pixel value = row*4+col+1):
- Reset:
  - Assert rst for 3 cycles.
  - Required: all outputs 0 during rst; rtr_I=1 one cycle after release; rts_II=0.
- Row 0, pixels 1..4, rtr_II tied high:
  - rts_II pulses after each pixel; all ilb_byte_* = 0.
  - lines_valid 0 until the 4th WRITE, then 1; col_ptr wraps to 0.
- Row 1, pixel 5:
  - ilb_byte_0=1, ilb_byte_1..5=0.
  - rts_II rises in the cycle after edge A+2.
- Rows 0..6 streamed, at pixel 25 (row 6, col 0):
  - ilb_byte_0..5 = 21,17,13,9,5,1; lines_valid=6.
  - Continuing to row 7 keeps lines_valid at 6.
- Backpressure:
  - Hold rtr_II=0 for 5 cycles in PRESENT while rts_I=1 and pixel_in changes.
  - Required: rts_II stays 1, rtr_I stays 0, ilb_byte_* stable, no second accept.
  - Raise rtr_II: rts_II drops next edge. Bytes are still stable 3 cycles later.
- clear in PRESENT after row 3:
  - Required: rts_II=0 next cycle; lines_valid=0; col_ptr=0.
  - Next pixel returns all-zero bytes.
  - rst asserted together with clear gives the reset values.

Source files
------------

// File: rtl/ilb_line_buffer_pkg.sv
// Shared types and constants for the input line buffer (ILB).
package ilb_line_buffer_pkg;

    localparam int NUM_ILB_LINES = 6;
    localparam int PIXEL_W       = 8;

    typedef enum logic [1:0] {
        ILB_IDLE    = 2'd0,
        ILB_READ    = 2'd1,
        ILB_WRITE   = 2'd2,
        ILB_PRESENT = 2'd3
    } ilb_state_e;

    typedef logic [PIXEL_W-1:0] pixel_t;

    // Fully written row count, saturating once every line memory holds a row.
    function automatic logic [2:0] lines_inc(input logic [2:0] lv);
        return (lv >= 3'(NUM_ILB_LINES)) ? 3'(NUM_ILB_LINES) : lv + 3'd1;
    endfunction

endpackage

// File: rtl/ilb_line_buffer_if.sv
// Transaction I (pixel in) and Transaction II (old column out) handshake bundle.
interface ilb_line_buffer_if;
    import ilb_line_buffer_pkg::*;

    pixel_t pixel_in;
    logic   sop_to_ilb_rts_I;
    logic   sop_to_ilb_rtr_I;
    logic   sop_to_ilb_rts_II;
    logic   sop_to_ilb_rtr_II;
    pixel_t ilb_byte_0;
    pixel_t ilb_byte_1;
    pixel_t ilb_byte_2;
    pixel_t ilb_byte_3;
    pixel_t ilb_byte_4;
    pixel_t ilb_byte_5;

    modport slave (
        input  pixel_in, sop_to_ilb_rts_I, sop_to_ilb_rtr_II,
        output sop_to_ilb_rtr_I, sop_to_ilb_rts_II,
        output ilb_byte_0, ilb_byte_1, ilb_byte_2, ilb_byte_3, ilb_byte_4, ilb_byte_5
    );

    modport master (
        output pixel_in, sop_to_ilb_rts_I, sop_to_ilb_rtr_II,
        input  sop_to_ilb_rtr_I, sop_to_ilb_rts_II,
        input  ilb_byte_0, ilb_byte_1, ilb_byte_2, ilb_byte_3, ilb_byte_4, ilb_byte_5
    );

endinterface

// File: rtl/ilb_line_buffer_line_ram.sv
// Single-port line memory: synchronous read, read-first when writing the same address.
module ilb_line_ram
    import ilb_line_buffer_pkg::*;
#(
    parameter int DEPTH = 28,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          en_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  pixel_t        wdata_i,
    output pixel_t        rdata_o
);

    pixel_t mem_q [DEPTH];
    pixel_t rdata_q;

    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) begin
                mem_q[addr_i] <= wdata_i;
            end
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ilb_line_buffer.sv
// Input line buffer: accepts one pixel per transaction and returns the six pixels
// above it in the same column from six cascaded line memories.
module ilb_line_buffer
    import ilb_line_buffer_pkg::*;
#(
    parameter int IMG_WIDTH = 28,
    parameter int COL_W     = $clog2(IMG_WIDTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    ilb_line_buffer_if.slave  ilb,
    output logic [2:0]        lines_valid,
    output logic [COL_W-1:0]  col_ptr
);

    ilb_state_e       state_q, state_d;
    logic             rtr_q, rtr_d;
    logic             rts_q, rts_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [2:0]       lv_q, lv_d;
    pixel_t           byte_q [NUM_ILB_LINES];
    pixel_t           byte_d [NUM_ILB_LINES];
    pixel_t           pix_q;
    pixel_t           ram_rdata [NUM_ILB_LINES];
    pixel_t           ram_wdata [NUM_ILB_LINES];
    logic             ram_en, ram_we, accept;

    for (genvar k = 0; k < NUM_ILB_LINES; k++) begin : g_line
        ilb_line_ram #(
            .DEPTH (IMG_WIDTH),
            .AW    (COL_W)
        ) u_ram (
            .clk     (clk),
            .en_i    (ram_en),
            .we_i    (ram_we),
            .addr_i  (col_q),
            .wdata_i (ram_wdata[k]),
            .rdata_o (ram_rdata[k])
        );
    end

    // Each line shifts one row down: line0 takes the new pixel, line k takes old line k-1.
    always_comb begin
        ram_wdata[0] = pix_q;
        for (int k = 1; k < NUM_ILB_LINES; k++) begin
            ram_wdata[k] = ram_rdata[k-1];
        end
    end

    always_comb begin
        state_d = state_q;
        rts_d   = rts_q;
        col_d   = col_q;
        lv_d    = lv_q;
        byte_d  = byte_q;
        ram_en  = 1'b0;
        ram_we  = 1'b0;
        accept  = 1'b0;

        unique case (state_q)
            ILB_IDLE: begin
                if (ilb.sop_to_ilb_rts_I && rtr_q) begin
                    accept  = 1'b1;
                    state_d = ILB_READ;
                end
            end
            ILB_READ: begin
                ram_en  = 1'b1;
                state_d = ILB_WRITE;
            end
            ILB_WRITE: begin
                ram_en = 1'b1;
                ram_we = 1'b1;
                // Rows not yet written in this frame read back as zero.
                for (int k = 0; k < NUM_ILB_LINES; k++) begin
                    byte_d[k] = (3'(k) < lv_q) ? ram_rdata[k] : '0;
                end
                if (col_q == COL_W'(IMG_WIDTH - 1)) begin
                    col_d = '0;
                    lv_d  = lines_inc(lv_q);
                end else begin
                    col_d = col_q + COL_W'(1);
                end
                rts_d   = 1'b1;
                state_d = ILB_PRESENT;
            end
            ILB_PRESENT: begin
                if (ilb.sop_to_ilb_rtr_II) begin
                    rts_d   = 1'b0;
                    state_d = ILB_IDLE;
                end
            end
            default: state_d = ILB_IDLE;
        endcase

        if (clear) begin
            state_d = ILB_IDLE;
            rts_d   = 1'b0;
            col_d   = '0;
            lv_d    = '0;
            ram_en  = 1'b0;
            ram_we  = 1'b0;
            accept  = 1'b0;
            for (int k = 0; k < NUM_ILB_LINES; k++) begin
                byte_d[k] = '0;
            end
        end

        rtr_d = (state_d == ILB_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ILB_IDLE;
            rtr_q   <= 1'b0;
            rts_q   <= 1'b0;
            col_q   <= '0;
            lv_q    <= '0;
            for (int k = 0; k < NUM_ILB_LINES; k++) begin
                byte_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            rtr_q   <= rtr_d;
            rts_q   <= rts_d;
            col_q   <= col_d;
            lv_q    <= lv_d;
            byte_q  <= byte_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            pix_q <= ilb.pixel_in;
        end
    end

    assign ilb.sop_to_ilb_rtr_I  = rtr_q;
    assign ilb.sop_to_ilb_rts_II = rts_q;
    assign ilb.ilb_byte_0        = byte_q[0];
    assign ilb.ilb_byte_1        = byte_q[1];
    assign ilb.ilb_byte_2        = byte_q[2];
    assign ilb.ilb_byte_3        = byte_q[3];
    assign ilb.ilb_byte_4        = byte_q[4];
    assign ilb.ilb_byte_5        = byte_q[5];
    assign lines_valid           = lv_q;
    assign col_ptr               = col_q;

endmodule

// File: tb/tb_ilb_line_buffer.sv
// Scoreboard bench for ilb_line_buffer: frame-history reference model, decoupled monitor.
module tb_ilb_line_buffer;

    localparam int W  = 4;
    localparam int CW = $clog2(W);

    typedef struct {
        logic [5:0][7:0] b;
        int              lv;
        int              col;
        int              acc;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          clear;
    logic [2:0]    lines_valid;
    logic [CW-1:0] col_ptr;

    ilb_line_buffer_if bus ();

    ilb_line_buffer #(.IMG_WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear),
        .ilb         (bus),
        .lines_valid (lines_valid),
        .col_ptr     (col_ptr)
    );

    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    int   mode   = 1;
    int   frame[$];
    exp_t sb[$];
    exp_t last_exp;

    logic ctl_q = 1'b0, rst_q = 1'b0, hs_q = 1'b0, prev_rts_q = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [5:0][7:0] cur_bytes();
        return {bus.ilb_byte_5, bus.ilb_byte_4, bus.ilb_byte_3,
                bus.ilb_byte_2, bus.ilb_byte_1, bus.ilb_byte_0};
    endfunction

    // Reference: pixel n of the frame sits at row n/W, column n%W; byte k is the
    // pixel k+1 rows above in the same column, or zero if that row does not exist yet.
    function automatic exp_t model_push(input int pix, input int acc);
        exp_t e;
        int   n, r, c, idx;
        frame.push_back(pix);
        n = frame.size() - 1;
        r = n / W;
        c = n % W;
        for (int k = 0; k < 6; k++) begin
            idx     = r - 1 - k;
            e.b[k]  = (idx >= 0) ? 8'(frame[idx * W + c]) : 8'd0;
        end
        e.lv  = ((n + 1) / W > 6) ? 6 : (n + 1) / W;
        e.col = (n + 1) % W;
        e.acc = acc;
        return e;
    endfunction

    // Downstream consumer: 0 = always ready, 1 = never ready, other = random.
    always @(negedge clk) begin
        #1;
        case (mode)
            0:       bus.sop_to_ilb_rtr_II = 1'b1;
            1:       bus.sop_to_ilb_rtr_II = 1'b0;
            default: bus.sop_to_ilb_rtr_II = 1'($urandom_range(0, 1));
        endcase
    end

    always @(posedge clk) begin
        cyc        <= cyc + 1;
        ctl_q      <= rst | clear;
        rst_q      <= rst;
        hs_q       <= bus.sop_to_ilb_rts_II & bus.sop_to_ilb_rtr_II;
        prev_rts_q <= bus.sop_to_ilb_rts_II;
    end

    // Monitor: pops the scoreboard on every rts_II rise and polices output stability.
    logic [5:0][7:0] cur_b, last_b;
    bit              hold_v = 1'b0;
    exp_t            me;

    always @(negedge clk) begin
        cur_b = cur_bytes();
        if (ctl_q) begin
            chk("ctl_rts_II", bus.sop_to_ilb_rts_II, 0);
            chk("ctl_lines_valid", lines_valid, 0);
            chk("ctl_col_ptr", col_ptr, 0);
            for (int k = 0; k < 6; k++) chk($sformatf("ctl_byte_%0d", k), cur_b[k], 0);
            if (rst_q) chk("rst_rtr_I", bus.sop_to_ilb_rtr_I, 0);
            last_b = '0;
            hold_v = 1'b1;
        end else if (!prev_rts_q && bus.sop_to_ilb_rts_II) begin
            if (sb.size() > 0) begin
                me = sb.pop_front();
                chk("rts_II_latency", cyc, me.acc + 2);
                for (int k = 0; k < 6; k++) chk($sformatf("byte_%0d", k), cur_b[k], me.b[k]);
                chk("lines_valid", lines_valid, me.lv);
                chk("col_ptr", col_ptr, me.col);
            end else begin
                chk("sb_pending_on_rts_II", sb.size(), 1);
            end
            last_b = cur_b;
            hold_v = 1'b1;
        end else begin
            if (prev_rts_q) chk("rts_II_after_edge", bus.sop_to_ilb_rts_II, int'(!hs_q));
            if (hold_v) begin
                for (int k = 0; k < 6; k++) chk($sformatf("byte_%0d_stable", k), cur_b[k], last_b[k]);
            end
        end
        if (bus.sop_to_ilb_rts_II) chk("rtr_I_low_while_rts_II", bus.sop_to_ilb_rtr_I, 0);
    end

    task automatic wait_rtr_I();
        int w = 0;
        while (bus.sop_to_ilb_rtr_I !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (w >= 100) chk("rtr_I_timeout", bus.sop_to_ilb_rtr_I, 1);
    endtask

    task automatic wait_rts_II();
        int w = 0;
        while (bus.sop_to_ilb_rts_II !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("rts_II_seen", bus.sop_to_ilb_rts_II, 1);
    endtask

    task automatic send(input int pix, input bit hold);
        exp_t e;
        wait_rtr_I();
        bus.pixel_in         = 8'(pix);
        bus.sop_to_ilb_rts_I = 1'b1;
        e = model_push(pix, cyc + 1);
        sb.push_back(e);
        last_exp = e;
        @(negedge clk);
        if (!hold) bus.sop_to_ilb_rts_I = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        frame.delete();
        @(negedge clk);
        clear = 1'b0;
    endtask

    initial begin
        logic [7:0] lit [6];
        exp_t       bp;
        lit = '{8'd21, 8'd17, 8'd13, 8'd9, 8'd5, 8'd1};

        rst                  = 1'b1;
        clear                = 1'b0;
        bus.pixel_in         = '0;
        bus.sop_to_ilb_rts_I = 1'b0;
        mode                 = 1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("release_rtr_I", bus.sop_to_ilb_rtr_I, 1);
        chk("release_rts_II", bus.sop_to_ilb_rts_II, 0);

        // Rows 0..7 with pixel = row*4+col+1, downstream always ready.
        mode = 0;
        for (int n = 0; n < 32; n++) begin
            send(n + 1, 1'b0);
            if (n == 24) begin
                repeat (2) @(negedge clk);
                for (int k = 0; k < 6; k++) begin
                    chk($sformatf("px25_byte_%0d", k), cur_bytes()[k], lit[k]);
                end
                chk("px25_lines_valid", lines_valid, 6);
            end
        end
        wait_rtr_I();
        chk("row7_lines_valid_sat", lines_valid, 6);

        // Backpressure: consumer stalls while upstream keeps offering new pixels.
        mode = 1;
        @(negedge clk);
        send(8'hA5, 1'b1);
        wait_rts_II();
        bp = last_exp;
        repeat (5) begin
            bus.pixel_in = 8'($urandom_range(0, 255));
            @(negedge clk);
            chk("bp_rts_II_held", bus.sop_to_ilb_rts_II, 1);
            chk("bp_rtr_I_low", bus.sop_to_ilb_rtr_I, 0);
        end
        mode                 = 0;
        bus.sop_to_ilb_rts_I = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("bp_rts_II_drop", bus.sop_to_ilb_rts_II, 0);
        repeat (3) @(negedge clk);
        for (int k = 0; k < 6; k++) chk($sformatf("bp_byte_%0d_after", k), cur_bytes()[k], bp.b[k]);

        // Random pixels, random upstream gaps, random downstream readiness.
        mode = 2;
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send(int'($urandom_range(0, 255)), 1'b0);
        end
        mode = 0;
        wait_rtr_I();

        // Fresh frame, rows 0..3, then clear while a column is being presented.
        do_clear();
        for (int n = 0; n < 16; n++) send(n + 1, 1'b0);
        wait_rtr_I();
        mode = 1;
        @(negedge clk);
        send(17, 1'b0);
        wait_rts_II();
        clear = 1'b1;
        frame.delete();
        @(negedge clk);
        clear = 1'b0;
        chk("clear_rts_II", bus.sop_to_ilb_rts_II, 0);
        chk("clear_lines_valid", lines_valid, 0);
        chk("clear_col_ptr", col_ptr, 0);
        @(negedge clk);
        chk("clear_rtr_I", bus.sop_to_ilb_rtr_I, 1);
        mode = 0;
        send(99, 1'b0);
        wait_rtr_I();

        // rst together with clear gives the reset values.
        rst   = 1'b1;
        clear = 1'b1;
        @(negedge clk);
        chk("rstclr_rtr_I", bus.sop_to_ilb_rtr_I, 0);
        chk("rstclr_rts_II", bus.sop_to_ilb_rts_II, 0);
        chk("rstclr_lines_valid", lines_valid, 0);
        chk("rstclr_col_ptr", col_ptr, 0);
        rst   = 1'b0;
        clear = 1'b0;
        frame.delete();
        @(negedge clk);
        chk("rstclr_release_rtr_I", bus.sop_to_ilb_rtr_I, 1);

        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
